// File: rtl/mnist_img_loader_if.sv
// Bundled pixel-stream, accelerator and result signals of the MNIST image loader.
// The loader uses the slave view, the driving environment uses the master view.
interface mnist_img_loader_if #(
  parameter int N_PIX = 784,
  parameter int PIX_W = 8
);
  logic                     in_valid;
  logic                     in_sof;
  logic [7:0]               in_pixel;
  logic                     in_ready;
  logic [N_PIX*PIX_W-1:0]   img_data;
  logic                     acc_start;
  logic                     acc_done;
  logic [3:0]               acc_pred;
  logic                     res_valid;
  logic                     res_ready;
  logic [3:0]               res_digit;
  logic                     frame_err;
  logic [15:0]              frame_cnt;

  modport master (
    output in_valid, in_sof, in_pixel, acc_done, acc_pred, res_ready,
    input  in_ready, img_data, acc_start, res_valid, res_digit, frame_err, frame_cnt
  );

  modport slave (
    input  in_valid, in_sof, in_pixel, acc_done, acc_pred, res_ready,
    output in_ready, img_data, acc_start, res_valid, res_digit, frame_err, frame_cnt
  );
endinterface

// File: rtl/mnist_img_loader.sv
// Collects a quantised frame of N_PIX pixels, kicks the accelerator, and hands
// its predicted digit downstream through a valid/ready result port.
module mnist_img_loader #(
  parameter int N_PIX = 784,
  parameter int PIX_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mnist_img_loader_if.slave    bus
);
  localparam int CNT_W = $clog2(N_PIX);
  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_START  = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESULT = 2'd3;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_PIX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]               state_q, state_d;
  logic [CNT_W-1:0]         pix_cnt_q, pix_cnt_d;
  logic [N_PIX*PIX_W-1:0]   img_data_q, img_data_d;
  logic                     in_ready_q, in_ready_d;
  logic                     acc_start_q, acc_start_d;
  logic                     res_valid_q, res_valid_d;
  logic [3:0]               res_digit_q, res_digit_d;
  logic                     frame_err_q, frame_err_d;
  logic [15:0]              frame_cnt_q, frame_cnt_d;

  logic                     accept_s;
  logic                     handshake_s;
  logic [CNT_W-1:0]         idx_s;

  // Next-state and datapath; a start-of-frame pixel always lands at index 0.
  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    img_data_d  = img_data_q;
    res_digit_d = res_digit_q;
    frame_cnt_d = frame_cnt_q;
    frame_err_d = 1'b0;
    accept_s    = bus.in_valid && in_ready_q;
    handshake_s = res_valid_q && bus.res_ready;
    idx_s       = bus.in_sof ? {CNT_W{1'b0}} : pix_cnt_q;

    case (state_q)
      ST_LOAD: begin
        if (accept_s) begin
          img_data_d[idx_s*PIX_W +: PIX_W] = PIX_W'({1'b0, bus.in_pixel[7:1]});
          frame_err_d = bus.in_sof && (pix_cnt_q != {CNT_W{1'b0}});
          if (idx_s == LAST_IDX) begin
            pix_cnt_d = {CNT_W{1'b0}};
            state_d   = ST_START;
          end else begin
            pix_cnt_d = idx_s + CNT_ONE;
          end
        end else begin
          pix_cnt_d = pix_cnt_q;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.acc_done) begin
          res_digit_d = bus.acc_pred;
          state_d     = ST_RESULT;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESULT: begin
        if (handshake_s) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = ST_LOAD;
        end else begin
          state_d = ST_RESULT;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase

    in_ready_d  = (state_d == ST_LOAD);
    acc_start_d = (state_d == ST_START);
    res_valid_d = (state_d == ST_RESULT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_LOAD;
      pix_cnt_q   <= {CNT_W{1'b0}};
      img_data_q  <= {(N_PIX*PIX_W){1'b0}};
      in_ready_q  <= 1'b0;
      acc_start_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_digit_q <= 4'd0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      img_data_q  <= img_data_d;
      in_ready_q  <= in_ready_d;
      acc_start_q <= acc_start_d;
      res_valid_q <= res_valid_d;
      res_digit_q <= res_digit_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.img_data  = img_data_q;
  assign bus.acc_start = acc_start_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_digit = res_digit_q;
  assign bus.frame_err = frame_err_q;
  assign bus.frame_cnt = frame_cnt_q;
endmodule
